// File: rtl/sprite_store.sv
`timescale 1ns/1ps
// sprite_store
//   Multi-slot sprite bitmap store. A raster-ordered pixel stream is loaded
//   into one slot, and any loaded slot can be read back per pixel.
//
//   Ports
//     clk, reset          : clock (rising edge) and asynchronous active-high reset
//     load_start/load_id  : begin loading slot load_id (honoured only when idle)
//     load_abort          : abandon the load in progress
//     src_valid/src_data  : pixel stream; src_ready is high while a load runs
//     load_busy           : a load is in progress
//     load_done           : one-cycle pulse after the final pixel is written
//     slot_loaded         : per-slot "holds a complete sprite" flags
//     rd_en/rd_id/rd_x/rd_y : read request; rd_valid/rd_color one cycle later
module sprite_store #(
   parameter  int SPR_W   = 20,
   parameter  int SPR_H   = 40,
   parameter  int COLOR_W = 3,
   parameter  int NUM_SPR = 4,
   localparam int IDW     = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load_start,
   input  logic [IDW-1:0]     load_id,
   input  logic               load_abort,
   input  logic               src_valid,
   input  logic [COLOR_W-1:0] src_data,
   output logic               src_ready,
   output logic               load_busy,
   output logic               load_done,
   output logic [NUM_SPR-1:0] slot_loaded,
   input  logic               rd_en,
   input  logic [IDW-1:0]     rd_id,
   input  logic [5:0]         rd_x,
   input  logic [5:0]         rd_y,
   output logic               rd_valid,
   output logic [COLOR_W-1:0] rd_color
);

   localparam int PIX   = SPR_W * SPR_H;
   localparam int DEPTH = NUM_SPR * PIX;
   localparam int AW    = $clog2(DEPTH);
   localparam int XW    = $clog2(SPR_W);
   localparam int YW    = $clog2(SPR_H);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [IDW-1:0]     id_q, id_d;
   logic [XW-1:0]      x_q, x_d;
   logic [YW-1:0]      y_q, y_d;
   logic [NUM_SPR-1:0] loaded_q, loaded_d;
   logic               rd_valid_q, rd_valid_d;
   logic [COLOR_W-1:0] rd_color_q, rd_color_d;

   // Storage is deliberately not reset; slot flags gate visibility instead.
   logic [COLOR_W-1:0] mem [DEPTH];

   logic          wr_en;
   logic          last_pix;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_addr;
   logic          rd_in_range;

   // Abort wins over a valid pixel, so an aborting cycle never writes.
   assign wr_en    = (state_q == S_LOAD) && src_valid && !load_abort;
   assign last_pix = (x_q == XW'(SPR_W - 1)) && (y_q == YW'(SPR_H - 1));
   assign wr_addr  = AW'(id_q) * AW'(PIX) + AW'(y_q) * AW'(SPR_W) + AW'(x_q);

   assign rd_in_range = (int'(rd_x) < SPR_W) && (int'(rd_y) < SPR_H);
   assign rd_addr     = AW'(rd_id) * AW'(PIX) + AW'(rd_y) * AW'(SPR_W) + AW'(rd_x);

   always_comb begin
      state_d  = state_q;
      id_d     = id_q;
      x_d      = x_q;
      y_d      = y_q;
      loaded_d = loaded_q;
      case (state_q)
         S_IDLE: begin
            if (load_start) begin
               state_d           = S_LOAD;
               id_d              = load_id;
               x_d               = '0;
               y_d               = '0;
               loaded_d[load_id] = 1'b0;
            end
         end
         S_LOAD: begin
            if (load_abort) begin
               state_d = S_IDLE;
            end else if (src_valid) begin
               if (last_pix) begin
                  // Flag goes up on entry to DONE so it coincides with load_done.
                  state_d        = S_DONE;
                  loaded_d[id_q] = 1'b1;
                  x_d            = '0;
                  y_d            = '0;
               end else if (x_q == XW'(SPR_W - 1)) begin
                  x_d = '0;
                  y_d = y_q + 1'b1;
               end else begin
                  x_d = x_q + 1'b1;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Out-of-range coordinates and unloaded slots read as transparent (0).
   always_comb begin
      rd_valid_d = rd_en;
      rd_color_d = '0;
      if (rd_en && rd_in_range && loaded_q[rd_id])
         rd_color_d = mem[rd_addr];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         id_q       <= '0;
         x_q        <= '0;
         y_q        <= '0;
         loaded_q   <= '0;
         rd_valid_q <= 1'b0;
         rd_color_q <= '0;
      end else begin
         state_q    <= state_d;
         id_q       <= id_d;
         x_q        <= x_d;
         y_q        <= y_d;
         loaded_q   <= loaded_d;
         rd_valid_q <= rd_valid_d;
         rd_color_q <= rd_color_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= src_data;
   end

   assign src_ready   = (state_q == S_LOAD);
   assign load_busy   = (state_q == S_LOAD);
   assign load_done   = (state_q == S_DONE);
   assign slot_loaded = loaded_q;
   assign rd_valid    = rd_valid_q;
   assign rd_color    = rd_color_q;

endmodule

// File: tb/tb_sprite_store.sv
`timescale 1ns/1ps
// tb_sprite_store
//   Directed bench for sprite_store at default parameters: full load, stalled
//   load, abort, read boundaries, reads concurrent with a load, and reset
//   during a load.
module tb_sprite_store;

   logic       clk = 1'b0;
   logic       reset;
   logic       load_start, load_abort, src_valid, src_ready, load_busy, load_done;
   logic [1:0] load_id, rd_id;
   logic [2:0] src_data, rd_color;
   logic [3:0] slot_loaded;
   logic       rd_en, rd_valid;
   logic [5:0] rd_x, rd_y;

   int n_chk = 0, n_fail = 0;
   int wr_cnt = 0, done_cnt = 0;
   int wr0, d0;

   sprite_store dut (
      .clk(clk), .reset(reset),
      .load_start(load_start), .load_id(load_id), .load_abort(load_abort),
      .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
      .load_busy(load_busy), .load_done(load_done), .slot_loaded(slot_loaded),
      .rd_en(rd_en), .rd_id(rd_id), .rd_x(rd_x), .rd_y(rd_y),
      .rd_valid(rd_valid), .rd_color(rd_color)
   );

   always #5 clk = ~clk;

   // Independent tally of accepted pixels and done pulses.
   always @(posedge clk) begin
      if (src_ready && src_valid && !load_abort) wr_cnt++;
      if (load_done) done_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] pv(input int i, input int mode);
      pv = (mode != 0) ? 3'((i * 3 + 1) % 8) : 3'(i % 8);
   endfunction

   task automatic start(input int id);
      load_start = 1'b1;
      load_id    = 2'(id);
      tick;
      load_start = 1'b0;
   endtask

   // Pixels 0..n-1; with stall, an idle cycle sits between consecutive pixels.
   task automatic feed(input int n, input bit stall, input int mode);
      for (int i = 0; i < n; i++) begin
         src_valid = 1'b1;
         src_data  = pv(i, mode);
         tick;
         if (stall && i < n - 1) begin
            src_valid = 1'b0;
            src_data  = 3'd5;
            tick;
         end
      end
      src_valid = 1'b0;
   endtask

   task automatic rd(input int id, input int x, input int y, input int exp, input string tag);
      rd_en = 1'b1;
      rd_id = 2'(id);
      rd_x  = 6'(x);
      rd_y  = 6'(y);
      tick;
      rd_en = 1'b0;
      chk({tag, "_vld"}, 32'(rd_valid), 32'd1);
      chk(tag, 32'(rd_color), 32'(exp));
   endtask

   initial begin
      reset = 1'b1; load_start = 1'b0; load_id = '0; load_abort = 1'b0;
      src_valid = 1'b0; src_data = '0; rd_en = 1'b0; rd_id = '0; rd_x = '0; rd_y = '0;
      repeat (3) tick;
      chk("rst_ready",  32'(src_ready),   32'd0);
      chk("rst_busy",   32'(load_busy),   32'd0);
      chk("rst_done",   32'(load_done),   32'd0);
      chk("rst_loaded", 32'(slot_loaded), 32'd0);
      chk("rst_rdv",    32'(rd_valid),    32'd0);
      reset = 1'b0;
      tick;

      rd(2, 5, 1, 0, "unloaded_rd");
      tick;
      chk("rdv_idle", 32'(rd_valid), 32'd0);

      // Full load into slot 2
      wr0 = wr_cnt; d0 = done_cnt;
      start(2);
      chk("ld_busy",  32'(load_busy), 32'd1);
      chk("ld_ready", 32'(src_ready), 32'd1);
      feed(800, 1'b0, 0);
      chk("full_done",   32'(load_done),   32'd1);
      chk("full_ready",  32'(src_ready),   32'd0);
      chk("full_loaded", 32'(slot_loaded), 32'h4);
      tick;
      chk("full_done_end", 32'(load_done), 32'd0);
      chk("full_busy_end", 32'(load_busy), 32'd0);
      chk("full_writes",   32'(wr_cnt - wr0),   32'd800);
      chk("full_pulses",   32'(done_cnt - d0),  32'd1);
      rd(2, 5, 1, 1, "s2_x5y1");
      rd(2, 7, 3, 3, "s2_x7y3");
      rd(2, 19, 39, 7, "s2_last");
      rd(2, 20, 0, 0, "s2_xoob");
      rd(2, 0, 40, 0, "s2_yoob");

      // Stalled load into slot 0
      wr0 = wr_cnt; d0 = done_cnt;
      start(0);
      feed(800, 1'b1, 0);
      chk("stall_done", 32'(load_done), 32'd1);
      tick;
      chk("stall_writes", 32'(wr_cnt - wr0),  32'd800);
      chk("stall_pulses", 32'(done_cnt - d0), 32'd1);
      chk("stall_loaded", 32'(slot_loaded),   32'h5);
      rd(0, 5, 1, 1, "s0_x5y1");
      rd(0, 6, 2, 6, "s0_x6y2");
      rd(0, 19, 39, 7, "s0_last");

      // Abort after 300 pixels into slot 1 (abort asserted alongside a valid pixel)
      wr0 = wr_cnt; d0 = done_cnt;
      start(1);
      feed(300, 1'b0, 0);
      load_abort = 1'b1; src_valid = 1'b1; src_data = 3'd5;
      tick;
      load_abort = 1'b0; src_valid = 1'b0;
      chk("abort_busy",   32'(load_busy),      32'd0);
      chk("abort_done",   32'(load_done),      32'd0);
      chk("abort_loaded", 32'(slot_loaded),    32'h5);
      chk("abort_writes", 32'(wr_cnt - wr0),   32'd300);
      chk("abort_pulses", 32'(done_cnt - d0),  32'd0);
      start(1);
      chk("restart_busy", 32'(load_busy), 32'd1);
      load_abort = 1'b1;
      tick;
      load_abort = 1'b0;
      chk("abort2_busy", 32'(load_busy), 32'd0);
      rd(1, 0, 0, 0, "s1_aborted");

      // Load slot 3 while reading slot 2 every cycle; a stray load_start mid-load
      start(3);
      for (int i = 0; i < 800; i++) begin
         src_valid = 1'b1;
         src_data  = pv(i, 1);
         rd_en = 1'b1; rd_id = 2'd2;
         rd_x  = 6'(i % 20);
         rd_y  = 6'(i / 20);
         if (i == 400) begin
            load_start = 1'b1;
            load_id    = 2'd0;
         end
         tick;
         load_start = 1'b0;
         chk("conc_rdv", 32'(rd_valid), 32'd1);
         chk("conc_rd",  32'(rd_color), 32'(pv(i, 0)));
      end
      src_valid = 1'b0; rd_en = 1'b0;
      chk("conc_done",   32'(load_done),   32'd1);
      chk("conc_loaded", 32'(slot_loaded), 32'hD);
      tick;
      rd(3, 5, 1, 4, "s3_x5y1");
      rd(3, 19, 39, 6, "s3_last");
      rd(0, 5, 1, 1, "s0_kept");

      // Reset in the middle of a load
      start(1);
      feed(400, 1'b0, 0);
      rd_en = 1'b1; rd_id = 2'd2; rd_x = 6'd5; rd_y = 6'd1;
      tick;
      rd_en = 1'b0;
      chk("pre_rst_rd", 32'(rd_color), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_busy",   32'(load_busy),   32'd0);
      chk("mid_rst_ready",  32'(src_ready),   32'd0);
      chk("mid_rst_done",   32'(load_done),   32'd0);
      chk("mid_rst_loaded", 32'(slot_loaded), 32'd0);
      chk("mid_rst_rdv",    32'(rd_valid),    32'd0);
      chk("mid_rst_rdc",    32'(rd_color),    32'd0);
      tick;
      reset = 1'b0;
      tick;
      wr0 = wr_cnt; d0 = done_cnt;
      start(1);
      feed(800, 1'b0, 0);
      chk("reload_done",   32'(load_done),   32'd1);
      chk("reload_loaded", 32'(slot_loaded), 32'h2);
      tick;
      chk("reload_writes", 32'(wr_cnt - wr0),  32'd800);
      chk("reload_pulses", 32'(done_cnt - d0), 32'd1);
      rd(1, 5, 1, 1, "s1_x5y1");
      rd(1, 7, 0, 7, "s1_x7y0");
      rd(1, 19, 39, 7, "s1_last");
      rd(2, 5, 1, 0, "s2_after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sprite_store.md
SPRITE_STORE -- requirements
Module: sprite_store

Interface
REQ-001 SHALL have parameter SPR_W, default 20, sprite width in pixels.
REQ-002 SHALL have parameter SPR_H, default 40, sprite height in pixels.
REQ-003 SHALL have parameter COLOR_W, default 3, bits per pixel colour.
REQ-004 SHALL have parameter NUM_SPR, default 4, number of sprite slots (power of two, >=1).
REQ-005 SHALL have clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have load_start  input  1  request to begin loading slot load_id.
REQ-008 SHALL have load_id  input  clog2(NUM_SPR)  slot to load, sampled with load_start.
REQ-009 SHALL have load_abort  input  1  abandon the current load.
REQ-010 SHALL have src_valid  input  1  src_data holds the next pixel in raster order.
REQ-011 SHALL have src_data  input  COLOR_W  pixel colour from the source stream.
REQ-012 SHALL have src_ready  output  1  block accepts a pixel this cycle.
REQ-013 SHALL have load_busy  output  1  a load is in progress.
REQ-014 SHALL have load_done  output  1  one-cycle pulse: the final pixel has been written.
REQ-015 SHALL have slot_loaded  output  NUM_SPR  per-slot flag: slot holds a complete sprite.
REQ-016 SHALL have rd_en  input  1  read request.
REQ-017 SHALL have rd_id  input  clog2(NUM_SPR)  slot to read.
REQ-018 SHALL have rd_x  input  6  pixel column; rd_y  input  6  pixel row.
REQ-019 SHALL have rd_valid  output  1  rd_color is valid this cycle.
REQ-020 SHALL have rd_color  output  COLOR_W  pixel colour read back.

Function
REQ-021 Storage SHALL be NUM_SPR*SPR_W*SPR_H words of COLOR_W bits, with address = id*SPR_W*SPR_H + y*SPR_W + x, and SHALL have independent write and read ports.
REQ-022 The FSM SHALL have states IDLE, LOAD and DONE; reset enters IDLE.
REQ-023 IDLE: load_start=1 -> LOAD; latch load_id; x=0, y=0; clear slot_loaded[load_id] in the same edge.
REQ-024 LOAD: src_ready=1 and load_busy=1; each cycle with src_valid=1 writes src_data at (x,y).
REQ-025 Raster advance: x increments; at x=SPR_W-1, x wraps to 0 and y increments.
REQ-026 A write at x=SPR_W-1, y=SPR_H-1 SHALL move the FSM to DONE; no further pixels are accepted.
REQ-027 DONE: for exactly one cycle, load_done=1, src_ready=0 and slot_loaded[latched id] is set; the FSM then returns to IDLE.
REQ-028 Cycles with src_valid=0 in LOAD SHALL stall without any write or counter change.
REQ-029 load_start while in LOAD or DONE SHALL be ignored.
REQ-030 load_abort in LOAD SHALL return the FSM to IDLE on the next edge with no write that cycle; the slot flag stays 0 and load_done is not pulsed.
REQ-031 load_abort outside LOAD SHALL be ignored; load_abort has priority over src_valid.
REQ-032 Read latency SHALL be one cycle: rd_en at edge N -> rd_valid=1 and rd_color after edge N; rd_valid=0 when rd_en was 0.
REQ-033 A read SHALL return rd_color=0 (transparent) if rd_x>=SPR_W, rd_y>=SPR_H, or slot_loaded[rd_id]=0 at the request edge.
REQ-034 A read of a loaded slot SHALL return the stored pixel; reads of other slots during a load are unaffected.
REQ-035 The width of x/y counters SHALL be clog2 of SPR_W/SPR_H, and the address width SHALL be clog2(NUM_SPR*SPR_W*SPR_H), with no truncation.

Reset
REQ-036 Asserting reset SHALL immediately force IDLE, src_ready=0, load_busy=0, load_done=0, slot_loaded=0, rd_valid=0, rd_color=0, and x=y=0.
REQ-037 Storage contents SHALL NOT be cleared by reset; slots read as transparent until they are reloaded.
REQ-038 Reset during LOAD SHALL abandon the load, and the next load_start after deassertion SHALL start cleanly at pixel (0,0).

Verification
REQ-039 Full load: load_start with id=2, then 800 consecutive pixels of value (i mod 8) -> load_done pulses once, 1 cycle after the 800th accepted pixel; slot_loaded=4'b0100; reading (x=5,y=1) returns 1 (index 25 mod 8).
REQ-040 Stalled stream: the same load with src_valid toggled 1,0,1,0 -> exactly 800 writes, and the final contents are identical to REQ-039.
REQ-041 Abort: abort after 300 pixels into slot 1 -> slot_loaded[1]=0, no load_done pulse, and a read of (0,0) in slot 1 returns 0; a load_start in the following cycle is accepted.
REQ-042 Boundaries: a read of (x=20,y=0) or (x=0,y=40) on a loaded slot returns 0 with rd_valid=1; a read of (19,39) returns the last pixel written.
REQ-043 Concurrency: read slot 2 every cycle while slot 3 loads -> slot 2 data is unchanged and has 1-cycle latency; a load_start issued mid-load is ignored.
REQ-044 Reset mid-load at pixel 400 -> all outputs return to their reset values immediately; a reload of the same slot then completes with load_done after 800 pixels.
